id_ex_stage: RTL

- ID/EX pipeline register for the 32I core, directly downstream of the ID control decoder.
- Captures the decoded control bundle, operands, immediate, PC and register indices each cycle and presents them registered to EX.
- Contains load-use hazard detection: holds IF/ID and injects a bubble into EX.
- Honours EX back-pressure and branch/jump flush; keeps a saturating bubble counter for performance monitoring.

---
 rtl/id_ex_stage.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register for the 32I core.
//
// Registers the decoded control bundle, operands, immediate, PC and register
// indices from ID and presents them to EX one cycle later. Detects the
// load-use hazard (a load in EX whose destination feeds the instruction in
// ID), holds IF/ID through id_stall and injects a bubble into EX. EX
// back-pressure (ex_stall) freezes every register; flush kills the ID
// instruction. bubble_cnt counts inserted load-use bubbles and saturates.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   id_valid, id_inst, id_pc    ID instruction, raw encoding and PC
//   id_rs1_data, id_rs2_data    register-file read data
//   id_imm                      sign-extended immediate
//   id_mem_read .. id_alu_op    decoder control bundle
//   ex_stall                    EX/MEM cannot accept; hold all state
//   flush                       taken branch/jump in EX; kill ID instruction
//   ex_*                        registered bundle presented to EX
//   id_stall                    combinational; IF/ID and PC must hold
//   bubble_cnt                  load-use bubbles inserted since reset
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [31:0]      id_inst,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_alu_src,
    input  logic             id_reg_write_n,
    input  logic [1:0]       id_mem_to_reg,
    input  logic [1:0]       id_jump,
    input  logic [1:0]       id_inst_size,
    input  logic [3:0]       id_alu_op,
    input  logic             ex_stall,
    input  logic             flush,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_alu_src,
    output logic             ex_reg_write_n,
    output logic [1:0]       ex_mem_to_reg,
    output logic [1:0]       ex_jump,
    output logic [1:0]       ex_inst_size,
    output logic [3:0]       ex_alu_op,
    output logic             id_stall,
    output logic [CNT_W-1:0] bubble_cnt
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            mem_read;
        logic            mem_write;
        logic            alu_src;
        logic            reg_write_n;
        logic [1:0]      mem_to_reg;
        logic [1:0]      jump;
        logic [1:0]      inst_size;
        logic [3:0]      alu_op;
    } ex_bundle_t;

    // A bubble is all-zero except the active-low write enable, which must
    // read as "no write".
    function automatic ex_bundle_t bubble();
        ex_bundle_t b;
        b = '0;
        b.reg_write_n = 1'b1;
        return b;
    endfunction

    ex_bundle_t bundle_p0;
    ex_bundle_t bundle_p1;
    logic       hazard;

    // ---- stage p0: ID inputs gathered, hazard against the bundle in EX ----
    always_comb begin
        bundle_p0             = '0;
        bundle_p0.valid       = id_valid;
        bundle_p0.pc          = id_pc;
        bundle_p0.rs1_data    = id_rs1_data;
        bundle_p0.rs2_data    = id_rs2_data;
        bundle_p0.imm         = id_imm;
        bundle_p0.rs1         = id_inst[19:15];
        bundle_p0.rs2         = id_inst[24:20];
        bundle_p0.rd          = id_inst[11:7];
        bundle_p0.mem_read    = id_mem_read;
        bundle_p0.mem_write   = id_mem_write;
        bundle_p0.alu_src     = id_alu_src;
        bundle_p0.reg_write_n = id_reg_write_n;
        bundle_p0.mem_to_reg  = id_mem_to_reg;
        bundle_p0.jump        = id_jump;
        bundle_p0.inst_size   = id_inst_size;
        bundle_p0.alu_op      = id_alu_op;
    end

    // Both source fields are compared whatever the instruction format; a
    // spurious stall on U/J-type costs one cycle and keeps the check cheap.
    assign hazard = id_valid & bundle_p1.valid & bundle_p1.mem_read &
                    (bundle_p1.rd != 5'd0) &
                    ((bundle_p1.rd == bundle_p0.rs1) | (bundle_p1.rd == bundle_p0.rs2));

    // Flush wins over the stall: the ID instruction is being discarded, so
    // IF/ID must be free to fetch the branch target.
    assign id_stall = ~reset & ~flush & (ex_stall | hazard);

    // ---- stage p1: registered bundle presented to EX ----
    always_ff @(posedge clk) begin
        if (reset) begin
            bundle_p1  <= bubble();
            bubble_cnt <= '0;
        end else if (flush) begin
            bundle_p1 <= bubble();
        end else if (!ex_stall) begin
            if (hazard) begin
                bundle_p1 <= bubble();
                if (bubble_cnt != '1) begin
                    bubble_cnt <= bubble_cnt + CNT_W'(1);
                end
            end else if (id_valid) begin
                bundle_p1 <= bundle_p0;
            end else begin
                bundle_p1 <= bubble();
            end
        end
    end

    assign ex_valid       = bundle_p1.valid;
    assign ex_pc          = bundle_p1.pc;
    assign ex_rs1_data    = bundle_p1.rs1_data;
    assign ex_rs2_data    = bundle_p1.rs2_data;
    assign ex_imm         = bundle_p1.imm;
    assign ex_rs1         = bundle_p1.rs1;
    assign ex_rs2         = bundle_p1.rs2;
    assign ex_rd          = bundle_p1.rd;
    assign ex_mem_read    = bundle_p1.mem_read;
    assign ex_mem_write   = bundle_p1.mem_write;
    assign ex_alu_src     = bundle_p1.alu_src;
    assign ex_reg_write_n = bundle_p1.reg_write_n;
    assign ex_mem_to_reg  = bundle_p1.mem_to_reg;
    assign ex_jump        = bundle_p1.jump;
    assign ex_inst_size   = bundle_p1.inst_size;
    assign ex_alu_op      = bundle_p1.alu_op;

endmodule
